// File: rtl/snake_pkg.sv
// Direction encoding and helpers shared by the input queue and the game engine.
// Pure definitions: no latency, no flow control.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;
  localparam dir_t DIR_RESET = DIR_DOWN;

  localparam int               SEED_W    = 26;
  localparam logic [SEED_W-1:0] SEED_INIT = 26'h155_5555;
  localparam int               MAX_DEPTH = 4;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite_dir(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> polarity normalise -> debounce -> registered press pulse.
// Latency 2 + DEBOUNCE_CYCLES clk from raw edge to pulse; no backpressure, pulses are fire-and-forget.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_LVL = ACTIVE_LOW;

  logic             sync1;
  logic             sync2;
  logic [1:0]       live;
  logic             armed;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             level;

  assign level = ACTIVE_LOW ? ~sync2 : sync2;

  // armed stays low until the synchronizer has carried a real released sample,
  // so a button held through reset never produces a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= IDLE_LVL;
      sync2  <= IDLE_LVL;
      live   <= 2'b00;
      armed  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      live  <= {live[0], 1'b1};
      if (live[1] && !level)
        armed <= 1'b1;
      press <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= level;
        press  <= level & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_input_queue.sv
// Four debounced arrow buttons feeding a small direction queue consumed on each game tick.
// Press enqueues 1 clk after its pulse; a full queue without a same-cycle pop drops and pulses drop.
module arrow_input_queue
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DEPTH           = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              tick,
  input  logic              clear,
  output logic [1:0]        dir,
  output logic [2:0]        queue_count,
  output logic              drop,
  output logic [SEED_W-1:0] seed
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic p_up, p_down, p_left, p_right;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_db_up (
    .clk(clk), .reset(reset), .btn(btn_up), .press(p_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_db_down (
    .clk(clk), .reset(reset), .btn(btn_down), .press(p_down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_db_left (
    .clk(clk), .reset(reset), .btn(btn_left), .press(p_left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_db_right (
    .clk(clk), .reset(reset), .btn(btn_right), .press(p_right));

  dir_t              q   [MAX_DEPTH];
  dir_t              q_n [MAX_DEPTH];
  logic [2:0]        cnt_n;
  logic              has_press;
  dir_t              press_dir;
  dir_t              ref_dir;
  logic              accept;
  logic              pop;
  logic              enq;
  logic [SEED_W-1:0] free_cnt;

  always_comb begin
    has_press = p_up | p_down | p_left | p_right;
    press_dir = DIR_RIGHT;
    if (p_left) press_dir = DIR_LEFT;
    if (p_down) press_dir = DIR_DOWN;
    if (p_up)   press_dir = DIR_UP;

    // A new press is judged against where the snake will be heading after the queue drains.
    ref_dir = (queue_count != 3'd0) ? q[2'(queue_count - 3'd1)] : dir;
    accept  = has_press && (press_dir != ref_dir) && (press_dir != opposite_dir(ref_dir));
    pop     = tick && (queue_count != 3'd0);
    enq     = accept && ((queue_count < DEPTH_C) || pop);

    q_n   = q;
    cnt_n = queue_count;
    if (pop) begin
      for (int i = 0; i < MAX_DEPTH - 1; i++)
        q_n[i] = q[i+1];
      cnt_n = queue_count - 3'd1;
    end
    if (enq) begin
      q_n[2'(cnt_n)] = press_dir;
      cnt_n          = cnt_n + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir         <= DIR_RESET;
      queue_count <= 3'd0;
      drop        <= 1'b0;
      seed        <= SEED_INIT;
      free_cnt    <= '0;
      for (int i = 0; i < MAX_DEPTH; i++)
        q[i] <= DIR_RESET;
    end else begin
      free_cnt <= free_cnt + 1'b1;
      if (clear) begin
        queue_count <= 3'd0;
        dir         <= DIR_RESET;
        drop        <= 1'b0;
      end else begin
        if (pop)
          dir <= q[0];
        q           <= q_n;
        queue_count <= cnt_n;
        drop        <= accept && !enq;
        if (accept)
          seed <= seed ^ free_cnt;
      end
    end
  end

endmodule
